// File: rtl/playback_sequencer_pkg.sv
// Shared constants, loop-mode codes and state encoding for the playback sequencer.
package playback_sequencer_pkg;

  localparam int DEF_SONG_BITS = 3;
  localparam int DEF_CNT_BITS  = 6;
  localparam int DEF_NUM_SONGS = 5;

  // Loop policy codes; 2'b11 behaves like LOOP_ALL.
  localparam logic [1:0] LOOP_STOP = 2'b00;
  localparam logic [1:0] LOOP_ONE  = 2'b01;
  localparam logic [1:0] LOOP_ALL  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_GAP     = 3'd3,
    ST_PAUSED  = 3'd4,
    ST_STOPPED = 3'd5
  } state_t;

  // States in which a song is considered to be in progress.
  function automatic logic is_active(state_t s);
    return (s == ST_FETCH) || (s == ST_PLAY) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/playback_sequencer_song_index_wrap.sv
// Combinational increment/decrement of a song number with wrap at NUM_SONGS.
module playback_sequencer_song_index_wrap #(
  parameter int SONG_BITS = 3,
  parameter int NUM_SONGS = 5
) (
  input  logic [SONG_BITS-1:0] i_song,
  output logic [SONG_BITS-1:0] o_inc,
  output logic [SONG_BITS-1:0] o_dec
);

  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);

  // Out-of-range song numbers are folded back to a valid song.
  assign o_inc = (i_song >= LAST_SONG) ? '0 : i_song + 1'b1;
  assign o_dec = ((i_song == '0) || (i_song > LAST_SONG)) ? LAST_SONG : i_song - 1'b1;

endmodule

// File: rtl/playback_sequencer.sv
// Auto-mode note scheduler: steps the Song ROM address and drives the
// Sound engine start/over handshake, with pause, skip and loop policy.
module playback_sequencer
  import playback_sequencer_pkg::*;
#(
  parameter int SONG_BITS  = DEF_SONG_BITS,
  parameter int CNT_BITS   = DEF_CNT_BITS,
  parameter int NUM_SONGS  = DEF_NUM_SONGS,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SONG_BITS-1:0] song_sel,
  input  logic                 play_pause,
  input  logic                 next,
  input  logic                 prev,
  input  logic [1:0]           loop_mode,
  output logic [SONG_BITS-1:0] rom_song,
  output logic [CNT_BITS-1:0]  rom_idx,
  input  logic [CNT_BITS-1:0]  rom_last,
  output logic                 snd_start,
  output logic                 snd_en,
  input  logic                 snd_over,
  output logic                 playing,
  output logic                 paused
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no silence configured a finished note goes straight to the next fetch.
  localparam state_t AFTER_NOTE = (GAP_CYCLES == 0) ? ST_FETCH : ST_GAP;

  state_t               r_state;
  logic [SONG_BITS-1:0] r_song;
  logic [CNT_BITS-1:0]  r_idx;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_snd_start;
  logic                 r_snd_en;
  logic                 r_playing;
  logic                 r_paused;

  state_t               w_state_next;
  logic [SONG_BITS-1:0] w_song_next;
  logic [CNT_BITS-1:0]  w_idx_next;
  logic [GAP_W-1:0]     w_gap_next;
  logic [SONG_BITS-1:0] w_song_inc;
  logic [SONG_BITS-1:0] w_song_dec;
  logic                 w_active;

  playback_sequencer_song_index_wrap #(
    .SONG_BITS(SONG_BITS),
    .NUM_SONGS(NUM_SONGS)
  ) u_wrap (
    .i_song(r_song),
    .o_inc (w_song_inc),
    .o_dec (w_song_dec)
  );

  assign w_active = is_active(r_state);

  // Next-state decision; the if-chain order is the control priority.
  always_comb begin
    w_state_next = r_state;
    w_song_next  = r_song;
    w_idx_next   = r_idx;
    w_gap_next   = '0;
    if (!en) begin
      w_state_next = ST_IDLE;
      w_song_next  = song_sel;
      w_idx_next   = '0;
    end else if (r_state == ST_IDLE) begin
      w_state_next = ST_FETCH;
    end else if (next) begin
      w_song_next = w_song_inc;
      w_idx_next  = '0;
      if (w_active) w_state_next = ST_FETCH;
    end else if (prev) begin
      // Mid-song prev restarts the song; at note 0 it steps back a song.
      if (r_idx != '0) w_idx_next = '0;
      else             w_song_next = w_song_dec;
      if (w_active) w_state_next = ST_FETCH;
    end else if (play_pause) begin
      case (r_state)
        ST_FETCH, ST_PLAY, ST_GAP: w_state_next = ST_PAUSED;
        ST_PAUSED:                 w_state_next = ST_FETCH;
        ST_STOPPED: begin
          w_state_next = ST_FETCH;
          w_idx_next   = '0;
        end
        default: ;
      endcase
    end else begin
      case (r_state)
        ST_FETCH: w_state_next = ST_PLAY;
        ST_PLAY: begin
          if (snd_over) begin
            if (r_idx < rom_last) begin
              w_idx_next   = r_idx + 1'b1;
              w_state_next = AFTER_NOTE;
            end else begin
              w_idx_next = '0;
              case (loop_mode)
                LOOP_STOP: w_state_next = ST_STOPPED;
                LOOP_ONE:  w_state_next = AFTER_NOTE;
                default: begin
                  w_song_next  = w_song_inc;
                  w_state_next = AFTER_NOTE;
                end
              endcase
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) w_state_next = ST_FETCH;
          else                       w_gap_next   = r_gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State, ROM address and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_song      <= '0;
      r_idx       <= '0;
      r_gap_cnt   <= '0;
      r_snd_start <= 1'b0;
      r_snd_en    <= 1'b0;
      r_playing   <= 1'b0;
      r_paused    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_song      <= w_song_next;
      r_idx       <= w_idx_next;
      r_gap_cnt   <= w_gap_next;
      r_snd_start <= (r_state == ST_FETCH) && (w_state_next == ST_PLAY);
      r_snd_en    <= (w_state_next == ST_PLAY);
      r_playing   <= is_active(w_state_next);
      r_paused    <= (w_state_next == ST_PAUSED);
    end
  end

  assign rom_song  = r_song;
  assign rom_idx   = r_idx;
  assign snd_start = r_snd_start;
  assign snd_en    = r_snd_en;
  assign playing   = r_playing;
  assign paused    = r_paused;

endmodule
